alu_serial_sequencer: RTL and testbench
=======================================

# alu_serial_sequencer

Bit-serial ALU controller for the 24-bit CPU. It accepts one full-width operation per request and drives a single 1-bit ALU slice (AND/OR/ADD/XOR with B-invert and carry-in) over WIDTH consecutive cycles, LSB first. It keeps the carry between bits, assembles the result and produces the Zero, Carry and Overflow flags. It sits between the control unit and the register-file write-back path, trading latency for a single slice of area.

## Interface
- WIDTH, 24, operand/result width in bits; legal range 2..32.
- Clock  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high; clears all state and outputs.
- Start  input  1  request pulse; sampled only while Busy=0.
- A  input  WIDTH  operand A; latched on accepted Start.
- B  input  WIDTH  operand B; latched on accepted Start.
- ALUCtrl  input  4  {BInvert, Op[2:0]}: 0000 AND, 0001 OR, 0010 ADD, 1010 SUB, 1011 SLT, 0101 XOR; all other codes are illegal.
- Busy  output  1  high while the block is serialising.
- Done  output  1  one-cycle pulse; Result and the flags are valid from this cycle onward.
- Result  output  WIDTH  operation result; held until the next Done.
- Zero  output  1  Result == 0.
- CarryOut  output  1  carry out of the MSB for ADD/SUB, else 0.
- Overflow  output  1  signed overflow for ADD/SUB, else 0.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE → RUN on Start.
  - RUN → DONE when BitCnt == WIDTH-1.
  - DONE → RUN if Start, else → IDLE.
- On accepted Start:
  - Latch A, B and ALUCtrl.
  - Clear BitCnt.
  - Carry register = BInvert (1 for SUB/SLT, 0 otherwise).
- RUN, each cycle with i = BitCnt:
  - Slice inputs: a = A[i], b = B[i] ^ BInvert, cin = carry register.
  - Slice function: AND → a&b; OR → a|b; ADD/SUB/SLT → a^b^cin; XOR → a^b.
  - Carry register ← a&b | a&cin | b&cin for the arithmetic ops; otherwise it is unused but still updated.
  - The result bit shifts into the MSB of a right-shifting accumulator, so after WIDTH shifts bit 0 is in place.
  - At i = WIDTH-1, record carry-in (Cm) and carry-out (Co) of the MSB.
- Final result and flags, registered on the RUN→DONE edge:
  - Overflow = Cm ^ Co for ADD/SUB.
  - CarryOut = Co for ADD/SUB.
  - SLT: Result = {0…0, sumMSB ^ (Cm ^ Co)}; CarryOut = 0; Overflow = 0.
  - Illegal ALUCtrl: the block still runs WIDTH cycles, then Result = 0, Zero = 1, CarryOut = 0, Overflow = 0.
  - Zero is computed from the final Result.
- Busy=1 in RUN only. A Start while Busy=1 is ignored with no effect. A, B and ALUCtrl may change freely after acceptance.
- Result and the flags are updated only at the DONE transition. They do not change during RUN, so the previous values remain visible.

## Timing
- Reset (synchronous, checked first each edge) gives: state IDLE, Busy=0, Done=0, Result=0, Zero=1, CarryOut=0, Overflow=0, BitCnt=0.
- Start accepted at edge 0:
  - Busy=1 from edge 0 through edge WIDTH-1.
  - Done=1 and the new Result are visible after edge WIDTH, for one cycle.
  - Total latency is WIDTH+1 cycles from the Start-sampling edge; 25 cycles at WIDTH=24.
- Back-to-back operation: Start asserted in the DONE cycle is accepted. Busy rises on the next edge, giving a throughput of one operation per WIDTH+1 cycles.
- Start held high continuously: the block re-launches in every DONE cycle using the operands present at that edge.
- Reset during RUN: the block aborts on that edge and returns to its reset values. No Done is issued, and any partial result is discarded.
- BitCnt width is ceil(log2(WIDTH)) and it never wraps. Leaving RUN is decided by compare, not by overflow.

## Test plan
- Basic add: ADD A=0x000001, B=0x000001, Start at cycle 0.
  - Busy is high for 24 cycles, then Done pulses at cycle 25.
  - Result=0x000002, Zero=0, CarryOut=0, Overflow=0.
- Wrap to zero: ADD 0xFFFFFF + 0x000001.
  - Result=0x000000, Zero=1, CarryOut=1, Overflow=0.
- Signed overflow: SUB 0x7FFFFF − 0xFFFFFF.
  - Result=0x800000, Overflow=1, CarryOut=0.
  - Then SUB 0x000005 − 0x000005 gives Result=0, Zero=1, CarryOut=1.
- Set-less-than: each case returns Result as shown with Overflow=0.
  - SLT 0xFFFFFE vs 0x000003 gives 0x000001.
  - SLT 0x800000 vs 0x000001 gives 0x000001 (overflow-corrected).
  - SLT 0x000003 vs 0xFFFFFE gives 0x000000.
- Logic ops with back-to-back launch: AND, OR and XOR of 0xF0F0F0 and 0x0FF00F, each started in the previous op's Done cycle.
  - Results are 0x00F000, 0xFFF0FF and 0xFF00FF.
  - Each Done is spaced 25 cycles apart.
- Robustness: Start pulse at RUN cycle 10, and Reset at RUN cycle 12 of a second operation.
  - The mid-run Start is ignored.
  - The Reset restores all reset values and produces no Done.
  - Illegal ALUCtrl 0111 completes in 25 cycles with Result=0 and Zero=1.

Source files
------------

// File: rtl/alu_serial_sequencer.sv
// Bit-serial ALU sequencer: runs one 1-bit ALU slice over WIDTH cycles,
// LSB first, and assembles the result and the Zero/CarryOut/Overflow flags.
module alu_serial_sequencer #(
    parameter int unsigned WIDTH = 24
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUCtrl,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             CarryOut,
    output logic             Overflow
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [3:0]       ctrl_reg;
    logic [CW-1:0]    bit_cnt;
    logic             carry;
    logic [WIDTH-1:0] acc;

    logic             a_bit;
    logic             b_bit;
    logic             res_bit;
    logic             carry_nxt;
    logic             msb_ovf;
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] fin_result;
    logic             fin_co;
    logic             fin_ov;

    // Slice evaluation for the current bit plus the final result/flags,
    // which are only consumed on the last RUN cycle (Cm = carry, Co = carry_nxt).
    always_comb begin
        a_bit     = a_reg[bit_cnt];
        b_bit     = b_reg[bit_cnt] ^ ctrl_reg[3];
        carry_nxt = (a_bit & b_bit) | (a_bit & carry) | (b_bit & carry);
        case (ctrl_reg[2:0])
            3'b000:  res_bit = a_bit & b_bit;
            3'b001:  res_bit = a_bit | b_bit;
            3'b101:  res_bit = a_bit ^ b_bit;
            default: res_bit = a_bit ^ b_bit ^ carry;
        endcase
        acc_nxt    = {res_bit, acc[WIDTH-1:1]};
        msb_ovf    = carry ^ carry_nxt;
        fin_result = '0;
        fin_co     = 1'b0;
        fin_ov     = 1'b0;
        case (ctrl_reg)
            4'b0000, 4'b0001, 4'b0101: fin_result = acc_nxt;
            4'b0010, 4'b1010: begin
                fin_result = acc_nxt;
                fin_co     = carry_nxt;
                fin_ov     = msb_ovf;
            end
            4'b1011: fin_result[0] = res_bit ^ msb_ovf;
            default: fin_result = '0;
        endcase
    end

    // Sequencer FSM with registered Busy/Done and result/flag registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= IDLE;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Result   <= '0;
            Zero     <= 1'b1;
            CarryOut <= 1'b0;
            Overflow <= 1'b0;
            bit_cnt  <= '0;
            carry    <= 1'b0;
            acc      <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            ctrl_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        a_reg    <= A;
                        b_reg    <= B;
                        ctrl_reg <= ALUCtrl;
                        bit_cnt  <= '0;
                        carry    <= ALUCtrl[3];
                        Busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    acc     <= acc_nxt;
                    carry   <= carry_nxt;
                    bit_cnt <= bit_cnt + CW'(1);
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt  <= '0;
                        Busy     <= 1'b0;
                        Done     <= 1'b1;
                        Result   <= fin_result;
                        Zero     <= (fin_result == '0);
                        CarryOut <= fin_co;
                        Overflow <= fin_ov;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        a_reg    <= A;
                        b_reg    <= B;
                        ctrl_reg <= ALUCtrl;
                        bit_cnt  <= '0;
                        carry    <= ALUCtrl[3];
                        Busy     <= 1'b1;
                        state    <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial_sequencer.sv
// Scoreboard bench for alu_serial_sequencer with directed, hand-computed vectors.
module tb_alu_serial_sequencer;

    localparam int W = 24;

    logic         Clock = 1'b0;
    logic         Reset;
    logic         Start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [3:0]   ALUCtrl;
    logic         Busy;
    logic         Done;
    logic [W-1:0] Result;
    logic         Zero;
    logic         CarryOut;
    logic         Overflow;

    alu_serial_sequencer #(.WIDTH(W)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Start    (Start),
        .A        (A),
        .B        (B),
        .ALUCtrl  (ALUCtrl),
        .Busy     (Busy),
        .Done     (Done),
        .Result   (Result),
        .Zero     (Zero),
        .CarryOut (CarryOut),
        .Overflow (Overflow)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [W-1:0] res;
        logic         z;
        logic         co;
        logic         ov;
        string        name;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Monitor: every Done pops one expected response and compares all outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clock);
            if (Done) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_done: Done=1 with no pending op, Result=%h", Result);
                end else begin
                    e = sb.pop_front();
                    if (Result !== e.res || Zero !== e.z || CarryOut !== e.co || Overflow !== e.ov) begin
                        n_err++;
                        $display("FAIL %s: got R=%h Z=%b C=%b V=%b, expected R=%h Z=%b C=%b V=%b",
                                 e.name, Result, Zero, CarryOut, Overflow, e.res, e.z, e.co, e.ov);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_vec++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, expv);
        end
    endtask

    task automatic check_reset_vals(input string name);
        chk({name, "_busy"},     {31'd0, Busy},     32'd0);
        chk({name, "_done"},     {31'd0, Done},     32'd0);
        chk({name, "_result"},   {8'd0, Result},    32'd0);
        chk({name, "_zero"},     {31'd0, Zero},     32'd1);
        chk({name, "_carryout"}, {31'd0, CarryOut}, 32'd0);
        chk({name, "_overflow"}, {31'd0, Overflow}, 32'd0);
    endtask

    // Drive one Start for one edge and record the expected response.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] c,
                         input logic [W-1:0] r, input logic z, input logic co, input logic ov,
                         input string name);
        exp_t e;
        e.res = r; e.z = z; e.co = co; e.ov = ov; e.name = name;
        sb.push_back(e);
        A = a; B = b; ALUCtrl = c; Start = 1'b1;
        @(posedge Clock);
        #1;
        Start   = 1'b0;
        A       = W'($urandom);
        B       = W'($urandom);
        ALUCtrl = 4'b1111;
    endtask

    // Follow one operation from its launch edge; optional mid-run Start poke or Reset.
    task automatic wait_done(input string name, input int poke_at, input int reset_at);
        int           lat  = 0;
        int           busy = 0;
        bit           held = 1'b1;
        logic [W-1:0] prev;
        prev = Result;
        while (1) begin
            @(negedge Clock);
            lat++;
            if (poke_at >= 0 && lat == poke_at) begin
                Start = 1'b1; A = 24'h00ABCD; B = 24'h001111; ALUCtrl = 4'b0001;
            end else if (poke_at >= 0 && lat == poke_at + 1) begin
                Start = 1'b0;
            end
            if (reset_at >= 0 && lat == reset_at) begin
                Reset = 1'b1;
                @(posedge Clock);
                #1;
                Reset = 1'b0;
                return;
            end
            if (Busy) busy++;
            if (Done) break;
            if (Result !== prev) held = 1'b0;
            if (lat >= 60) begin
                n_vec++;
                n_err++;
                $display("FAIL %s_timeout: no Done after %0d cycles, required 25", name, lat);
                return;
            end
        end
        chk({name, "_latency"},     lat,            32'd25);
        chk({name, "_busy_cycles"}, busy,           32'd24);
        chk({name, "_result_held"}, {31'd0, held},  32'd1);
    endtask

    initial begin
        int n_done;
        Reset = 1'b1; Start = 1'b0; A = '0; B = '0; ALUCtrl = 4'b0000;
        repeat (3) @(posedge Clock);
        #1;
        Reset = 1'b0;
        @(negedge Clock);
        check_reset_vals("reset");

        issue(24'h000001, 24'h000001, 4'b0010, 24'h000002, 1'b0, 1'b0, 1'b0, "add_basic");
        wait_done("add_basic", -1, -1);
        @(negedge Clock);
        issue(24'hFFFFFF, 24'h000001, 4'b0010, 24'h000000, 1'b1, 1'b1, 1'b0, "add_wrap");
        wait_done("add_wrap", -1, -1);
        @(negedge Clock);
        issue(24'h7FFFFF, 24'hFFFFFF, 4'b1010, 24'h800000, 1'b0, 1'b0, 1'b1, "sub_ovf");
        wait_done("sub_ovf", -1, -1);
        @(negedge Clock);
        issue(24'h000005, 24'h000005, 4'b1010, 24'h000000, 1'b1, 1'b1, 1'b0, "sub_equal");
        wait_done("sub_equal", -1, -1);
        @(negedge Clock);
        issue(24'hFFFFFE, 24'h000003, 4'b1011, 24'h000001, 1'b0, 1'b0, 1'b0, "slt_neg_pos");
        wait_done("slt_neg_pos", -1, -1);
        @(negedge Clock);
        issue(24'h800000, 24'h000001, 4'b1011, 24'h000001, 1'b0, 1'b0, 1'b0, "slt_ovf_fix");
        wait_done("slt_ovf_fix", -1, -1);
        @(negedge Clock);
        issue(24'h000003, 24'hFFFFFE, 4'b1011, 24'h000000, 1'b1, 1'b0, 1'b0, "slt_pos_neg");
        wait_done("slt_pos_neg", -1, -1);

        // Back-to-back: each launch is issued in the previous Done cycle.
        @(negedge Clock);
        issue(24'hF0F0F0, 24'h0FF00F, 4'b0000, 24'h00F000, 1'b0, 1'b0, 1'b0, "and_b2b");
        wait_done("and_b2b", -1, -1);
        issue(24'hF0F0F0, 24'h0FF00F, 4'b0001, 24'hFFF0FF, 1'b0, 1'b0, 1'b0, "or_b2b");
        wait_done("or_b2b", -1, -1);
        issue(24'hF0F0F0, 24'h0FF00F, 4'b0101, 24'hFF00FF, 1'b0, 1'b0, 1'b0, "xor_b2b");
        wait_done("xor_b2b", -1, -1);

        // Mid-run Start must be ignored.
        @(negedge Clock);
        issue(24'h000010, 24'h000020, 4'b0010, 24'h000030, 1'b0, 1'b0, 1'b0, "add_poked");
        wait_done("add_poked", 10, -1);

        // Reset mid-run aborts with no Done.
        @(negedge Clock);
        issue(24'h000123, 24'h000001, 4'b0010, 24'h000124, 1'b0, 1'b0, 1'b0, "add_aborted");
        wait_done("add_aborted", -1, 12);
        void'(sb.pop_back());
        @(negedge Clock);
        check_reset_vals("abort");
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clock);
            if (Done) n_done++;
        end
        chk("abort_no_done", n_done, 32'd0);

        // Illegal control code still runs the full length.
        issue(24'h123456, 24'h654321, 4'b0111, 24'h000000, 1'b1, 1'b0, 1'b0, "illegal_0111");
        wait_done("illegal_0111", -1, -1);

        repeat (5) @(negedge Clock);
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
